doubling_monitor: RTL
=====================

# doubling_monitor

Downstream checker for the 8-bit power-of-two doubling stage. Each cycle it samples the doubling stage's output and checks that the value follows 1, 2, 4 … 128, 0, 0 … (8-bit truncated doubling). It reports the current bit position and counts sequence faults. It also queues SYNC, WRAP and FAULT events into a small FIFO that a consumer drains over a valid/ready handshake.

## Interface
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2
- clk  input  1  system clock, all state updates on posedge
- rst_n  input  1  asynchronous, active-low reset
- in_value  input  8  doubling-stage output, sampled every posedge
- clear  input  1  synchronous; exits FAULT, flushes FIFO, clears ev_dropped
- state  output  2  current FSM state (SYNC=0, TRACK=1, WRAPPED=2, FAULT=3)
- log2_idx  output  3  bit position of sampled one-hot value
- idx_valid  output  1  log2_idx meaningful this cycle
- mismatch_count  output  8  FAULT entries, saturating at 255, cleared only by rst_n
- ev_valid  output  1  FIFO head valid (FIFO not empty)
- ev_ready  input  1  consumer accepts head when ev_valid & ev_ready
- ev_code  output  2  head event: SYNC=1, WRAP=2, FAULT=3
- ev_data  output  8  in_value captured with the head event
- ev_dropped  output  1  sticky; an event was lost to a full FIFO

## Operation
- prev_q holds the previous cycle's in_value. expected = {prev_q[6:0],1'b0}, which is 8-bit truncated.
- SYNC:
  - in_value==8'h01 → TRACK, push SYNC(01).
  - Any other value → stay in SYNC, no event.
- TRACK:
  - in_value==expected and in_value!=0 → stay in TRACK.
  - in_value==expected==0 (prev 0x80) → WRAPPED, push WRAP(00).
  - Any other value → FAULT, push FAULT(in_value), increment mismatch_count.
- WRAPPED:
  - in_value==0 → stay in WRAPPED.
  - in_value==01 → TRACK, push SYNC(01).
  - Any other value → FAULT, push FAULT(in_value), increment mismatch_count.
- FAULT: sticky. No events and no counting until clear.
- clear has priority over every transition:
  - Next state is SYNC.
  - FIFO is emptied, ev_dropped goes to 0, no push that cycle.
  - mismatch_count is kept.
- Index output:
  - idx_valid goes high the cycle after a sample where next state is TRACK and in_value is one-hot.
  - log2_idx is the encoded bit position of that sample; it holds its last value when idx_valid is low.
- FIFO behaviour:
  - Show-ahead: ev_code and ev_data are valid whenever ev_valid is high.
  - Push while full and no pop → event discarded, ev_dropped ← 1.
  - Push while full with a pop in the same cycle → push accepted, no drop.
  - Pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH; one extra pointer bit distinguishes full from empty.

## Timing
- Reset (rst_n low) values:
  - state=SYNC, prev_q=0, log2_idx=0, idx_valid=0, mismatch_count=0.
  - FIFO empty, so ev_valid=0, ev_code=0, ev_data=0; ev_dropped=0.
  - All take effect immediately and asynchronously.
- State, prev_q, the counter and FIFO writes update on the same posedge that samples in_value.
- Event latency: event condition on the sample at edge N → ev_valid high in cycle N+1, if the FIFO was empty.
- Index latency: one cycle from sample to log2_idx / idx_valid.
- Reset asserted mid-sequence: all state is lost. After release the block resynchronises on the next 01 sample.
- The doubling stage restarts at 01 after reset, so the first post-reset sample pushes SYNC(01).

## Structure
- Package doubling_monitor_pkg: state_t enum (SYNC/TRACK/WRAPPED/FAULT), ev_code_t enum (NONE=0/SYNC/WRAP/FAULT), event_t struct {ev_code_t code; logic [7:0] data}.
- Sub-module event_fifo:
  - Parameterised by DEPTH and element type event_t.
  - Ports: push, push_data, pop, head, empty, full, flush.
  - Owns the full/pop-same-cycle rule.
- Top level holds the FSM, prev_q, log2 encoder, saturating counter and ev_dropped.

## Test plan
- Reset release, in_value driven 01,02,…,80,00,00 → SYNC(01) then WRAP(00) eight cycles later; log2_idx 0…7 with idx_valid; state ends WRAPPED.
- TRACK, in_value 01,02,05 → FAULT, event FAULT(05), mismatch_count=1; clear pulse → state SYNC, FIFO empty, count stays 1.
- ev_ready=0, sequence 01…80,00,01…80,00,01 (5 events), FIFO_DEPTH=4 → 4 events held (SYNC,WRAP,SYNC,WRAP), ev_dropped=1.
- FIFO full with ev_ready=1 on the cycle a WRAP is pushed → head popped, WRAP accepted, ev_dropped stays 0.
- rst_n pulsed low mid-TRACK (in_value=10) → all outputs zero immediately; after release, next 01 → SYNC(01).
- 260 iterations of 01,03 then clear → mismatch_count saturates at 255.

Source files
------------

// File: rtl/doubling_monitor_pkg.sv
// Shared types and helpers for the doubling-stage monitor.
package doubling_monitor_pkg;

  // Checker FSM states; encodings are visible on the state output.
  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_WRAPPED = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  // Event codes carried through the event FIFO; NONE is the empty-head value.
  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_SYNC  = 2'd1,
    EV_WRAP  = 2'd2,
    EV_FAULT = 2'd3
  } ev_code_t;

  typedef struct packed {
    ev_code_t    code;
    logic [7:0]  data;
  } event_t;

  // First value of every doubling run.
  localparam logic [7:0] SEED_VALUE = 8'h01;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [7:0] v);
    return (v != '0) && ((v & (v - 8'd1)) == '0);
  endfunction

  // Bit position of a one-hot value (undefined input gives highest set bit).
  function automatic logic [2:0] encode_onehot(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/doubling_monitor_event_fifo.sv
// Show-ahead event FIFO with flush; accepts a push while full when the
// head is popped in the same cycle.
module event_fifo
  import doubling_monitor_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = event_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  input  logic flush,
  output T     head,
  output logic empty,
  output logic full
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  T            r_mem [DEPTH];

  logic w_pop_ok;
  logic w_push_ok;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop frees the slot the same cycle, so a full FIFO may still accept.
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  // Head is forced to zero when empty so the outputs read as NONE/0.
  assign head = empty ? T'('0) : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; flush empties the FIFO and overrides push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents are don't-care until the pointers expose them.
  always_ff @(posedge clk) begin
    if (w_push_ok && !flush) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/doubling_monitor.sv
// Checks that the doubling stage output follows 1,2,4..128,0,0.. and logs
// SYNC/WRAP/FAULT events into a FIFO drained over valid/ready.
module doubling_monitor
  import doubling_monitor_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_value,
  input  logic       clear,
  output logic [1:0] state,
  output logic [2:0] log2_idx,
  output logic       idx_valid,
  output logic [7:0] mismatch_count,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [1:0] ev_code,
  output logic [7:0] ev_data,
  output logic       ev_dropped
);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_prev;
  logic [7:0] w_expected;
  logic [2:0] r_log2_idx;
  logic       r_idx_valid;
  logic [7:0] r_mismatch_count;
  logic       r_ev_dropped;

  logic       w_push;
  event_t     w_push_ev;
  logic       w_fault_hit;
  logic       w_pop;
  logic       w_fifo_empty;
  logic       w_fifo_full;
  event_t     w_head;

  // 8-bit shift drops bit 7, giving the truncated doubling directly.
  assign w_expected = r_prev << 1;

  // Next-state and event selection; clear wins over every transition.
  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    w_push_ev    = '{code: EV_NONE, data: '0};
    w_fault_hit  = 1'b0;
    if (clear) begin
      w_next_state = ST_SYNC;
    end else begin
      case (r_state)
        ST_SYNC: begin
          if (in_value == SEED_VALUE) begin
            w_next_state = ST_TRACK;
            w_push       = 1'b1;
            w_push_ev    = '{code: EV_SYNC, data: in_value};
          end
        end
        ST_TRACK: begin
          if (in_value == w_expected && in_value != '0) begin
            w_next_state = ST_TRACK;
          end else if (in_value == w_expected) begin
            w_next_state = ST_WRAPPED;
            w_push       = 1'b1;
            w_push_ev    = '{code: EV_WRAP, data: in_value};
          end else begin
            w_next_state = ST_FAULT;
            w_push       = 1'b1;
            w_push_ev    = '{code: EV_FAULT, data: in_value};
            w_fault_hit  = 1'b1;
          end
        end
        ST_WRAPPED: begin
          if (in_value == '0) begin
            w_next_state = ST_WRAPPED;
          end else if (in_value == SEED_VALUE) begin
            w_next_state = ST_TRACK;
            w_push       = 1'b1;
            w_push_ev    = '{code: EV_SYNC, data: in_value};
          end else begin
            w_next_state = ST_FAULT;
            w_push       = 1'b1;
            w_push_ev    = '{code: EV_FAULT, data: in_value};
            w_fault_hit  = 1'b1;
          end
        end
        default: begin
          w_next_state = ST_FAULT;
        end
      endcase
    end
  end

  // State register and previous-sample capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SYNC;
      r_prev  <= '0;
    end else begin
      r_state <= w_next_state;
      r_prev  <= in_value;
    end
  end

  // Bit-position report for samples that keep or enter tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_log2_idx  <= '0;
      r_idx_valid <= 1'b0;
    end else if (w_next_state == ST_TRACK && is_onehot(in_value)) begin
      r_log2_idx  <= encode_onehot(in_value);
      r_idx_valid <= 1'b1;
    end else begin
      r_idx_valid <= 1'b0;
    end
  end

  // Saturating fault counter; survives clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch_count <= '0;
    end else if (w_fault_hit && r_mismatch_count != '1) begin
      r_mismatch_count <= r_mismatch_count + 8'd1;
    end
  end

  // Sticky drop flag: a push that the full FIFO could not take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ev_dropped <= 1'b0;
    end else if (clear) begin
      r_ev_dropped <= 1'b0;
    end else if (w_push && w_fifo_full && !w_pop) begin
      r_ev_dropped <= 1'b1;
    end
  end

  assign w_pop = ev_ready && !w_fifo_empty;

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (event_t)
  ) u_event_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_ev),
    .pop       (ev_ready),
    .flush     (clear),
    .head      (w_head),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full)
  );

  assign state          = r_state;
  assign log2_idx       = r_log2_idx;
  assign idx_valid      = r_idx_valid;
  assign mismatch_count = r_mismatch_count;
  assign ev_valid       = !w_fifo_empty;
  assign ev_code        = w_head.code;
  assign ev_data        = w_head.data;
  assign ev_dropped     = r_ev_dropped;

endmodule
